// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module : alu_seq_pkg
// Brief  : Operation and sequencer state encodings for the serial ALU.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_seq_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_ZERO = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic logic is_add(input logic [1:0] op);
    return op == OP_ADD;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_bit_slice.sv
// ============================================================================
// Module : alu_bit_slice
// Brief  : Combinational 1-bit ALU slice (AND / OR / full-adder sum / zero).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_bit_slice
  import alu_seq_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       y,
  output logic       cout
);

  always_comb begin
    y = 1'b0;
    unique case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_ADD:  y = a ^ b ^ cin;
      OP_ZERO: y = 1'b0;
      default: y = 1'b0;
    endcase
  end

  // Carry is always the full-adder carry; the sequencer masks it for non-ADD ops.
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/serial_alu_sequencer.sv
// ============================================================================
// Module : serial_alu_sequencer
// Brief  : Runs WIDTH-bit AND/OR/ADD/ZERO through one ALU slice, LSB first,
//          with a BUSY/DONE handshake and a held RESULT/COUT.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module serial_alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             COUT
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic             start_q;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [1:0]       op_q;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             start_rise;
  logic             slice_y;
  logic             slice_cout;
  logic             next_carry;
  logic [WIDTH-1:0] next_res;

  assign start_rise = START & ~start_q;

  alu_bit_slice u_slice (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .op   (op_q),
    .y    (slice_y),
    .cout (slice_cout)
  );

  // The carry register only ever holds a live value for ADD.
  assign next_carry = is_add(op_q) ? slice_cout : 1'b0;
  assign next_res   = {slice_y, res_sr[WIDTH-1:1]};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      start_q <= 1'b1;
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      op_q    <= OP_AND;
      carry   <= 1'b0;
      cnt     <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      RESULT  <= '0;
      COUT    <= 1'b0;
    end else begin
      start_q <= START;
      DONE    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_rise) begin
            a_sr  <= A;
            b_sr  <= B;
            op_q  <= OP;
            carry <= is_add(OP) ? CIN : 1'b0;
            cnt   <= '0;
            BUSY  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          res_sr <= next_res;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= next_carry;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            RESULT <= next_res;
            COUT   <= next_carry;
            DONE   <= 1'b1;
            BUSY   <= 1'b0;
            state  <= FIN;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_alu_sequencer.sv
// ============================================================================
// Module : tb_serial_alu_sequencer
// Brief  : Self-checking bench: vector table, corner sequences, random ops.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_serial_alu_sequencer;

  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         START = 1'b0;
  logic [1:0]   OP = 2'b00;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         CIN = 1'b0;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] RESULT;
  logic         COUT;

  int tests = 0;
  int failed = 0;
  logic [W-1:0] prev_res = '0;
  logic         prev_cout = 1'b0;

  always #5 CLK = ~CLK;

  serial_alu_sequencer #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .OP(OP), .A(A), .B(B), .CIN(CIN),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .COUT(COUT)
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_res;
    logic         exp_cout;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model straight from the operation definitions.
  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, output logic [W-1:0] r, output logic co);
    int sum;
    sum = int'(a) + int'(b) + int'(cin);
    case (op)
      2'b00:   begin r = a & b; co = 1'b0; end
      2'b01:   begin r = a | b; co = 1'b0; end
      2'b10:   begin r = W'(sum); co = (sum >= (1 << W)); end
      default: begin r = '0; co = 1'b0; end
    endcase
  endtask

  // Called at a negedge in an IDLE cycle with START low; returns at a negedge in IDLE.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic [W-1:0] er, input logic ec,
                        input string nm);
    int n;
    bit hold_bad;
    OP = op; A = a; B = b; CIN = cin; START = 1'b1;
    @(negedge CLK);
    check({nm, "_busy"}, BUSY, 1);
    START = 1'b0;
    A = W'($urandom); B = W'($urandom); OP = 2'($urandom); CIN = 1'($urandom);
    n = 0;
    hold_bad = 0;
    while (DONE !== 1'b1 && n < 40) begin
      if (RESULT !== prev_res || COUT !== prev_cout) hold_bad = 1;
      @(negedge CLK);
      n++;
    end
    check({nm, "_latency"}, n, W);
    check({nm, "_hold"}, hold_bad, 0);
    check({nm, "_result"}, RESULT, er);
    check({nm, "_cout"}, COUT, ec);
    check({nm, "_busy_fin"}, BUSY, 0);
    prev_res = er;
    prev_cout = ec;
    @(negedge CLK);
    check({nm, "_done_pulse"}, DONE, 0);
  endtask

  vec_t vecs[8];

  initial begin
    int dones;
    logic [W-1:0] cap;
    logic [1:0] rop;
    logic [W-1:0] ra, rb, rr;
    logic rc, rco;

    vecs[0] = '{2'b10, 4'b0111, 4'b0011, 1'b0, 4'b1010, 1'b0};
    vecs[1] = '{2'b10, 4'b1111, 4'b0001, 1'b1, 4'b0001, 1'b1};
    vecs[2] = '{2'b00, 4'b1100, 4'b1010, 1'b1, 4'b1000, 1'b0};
    vecs[3] = '{2'b01, 4'b1100, 4'b1010, 1'b0, 4'b1110, 1'b0};
    vecs[4] = '{2'b11, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0};
    vecs[5] = '{2'b10, 4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1};
    vecs[6] = '{2'b10, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0};
    vecs[7] = '{2'b00, 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b0};

    repeat (3) @(negedge CLK);
    check("reset_busy", BUSY, 0);
    check("reset_done", DONE, 0);
    check("reset_result", RESULT, 0);
    check("reset_cout", COUT, 0);
    RESET = 1'b0;
    @(negedge CLK);

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin,
                             vecs[i].exp_res, vecs[i].exp_cout, $sformatf("vec%0d", i));

    // START held across a whole op must produce exactly one completion.
    OP = 2'b10; A = 4'b0011; B = 4'b0100; CIN = 1'b0; START = 1'b1;
    dones = 0;
    repeat (3 * W) begin
      @(negedge CLK);
      if (DONE === 1'b1) dones++;
    end
    check("held_done_count", dones, 1);
    check("held_result", RESULT, 4'b0111);
    START = 1'b0;
    prev_res = 4'b0111; prev_cout = 1'b0;
    repeat (2) @(negedge CLK);
    check("held_release_idle", BUSY, 0);

    // A second press during BUSY with new operands is ignored.
    OP = 2'b01; A = 4'b1100; B = 4'b1010; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    OP = 2'b00; A = 4'b0000; B = 4'b0000; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    dones = 0;
    cap = '0;
    repeat (3 * W) begin
      @(negedge CLK);
      if (DONE === 1'b1) begin dones++; cap = RESULT; end
    end
    check("ignore_done_count", dones, 1);
    check("ignore_result", cap, 4'b1110);
    prev_res = 4'b1110; prev_cout = 1'b0;

    // Result held at 1010 while operands wiggle mid-RUN (run_op scrambles inputs).
    run_op(2'b10, 4'b0111, 4'b0011, 1'b0, 4'b1010, 1'b0, "pre_hold");
    run_op(2'b10, 4'b0001, 4'b0010, 1'b0, 4'b0011, 1'b0, "midrun_change");

    // Reset landing on the edge that would process bit 2.
    OP = 2'b10; A = 4'b0101; B = 4'b0011; CIN = 1'b0; START = 1'b1;
    @(negedge CLK);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check("abort_busy", BUSY, 0);
    check("abort_done", DONE, 0);
    check("abort_result", RESULT, 0);
    check("abort_cout", COUT, 0);
    RESET = 1'b0;
    dones = 0;
    repeat (3 * W) begin
      @(negedge CLK);
      if (DONE === 1'b1 || BUSY === 1'b1) dones++;
    end
    check("held_through_reset_no_op", dones, 0);
    START = 1'b0;
    prev_res = '0; prev_cout = 1'b0;
    @(negedge CLK);
    run_op(2'b10, 4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, "after_reset");

    // Random back-to-back operations against the model.
    for (int k = 0; k < 40; k++) begin
      rop = 2'($urandom); ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      model(rop, ra, rb, rc, rr, rco);
      run_op(rop, ra, rb, rc, rr, rco, $sformatf("rand%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
